// File: rtl/serial_add.sv
`default_nettype none
// ============================================================================
// Module      : serial_add
// Description : Bit-serial WIDTH-bit adder. Two operands are accepted over a
//               valid/ready handshake, added LSB-first one bit per clock with
//               a single full-adder cell and a carry flip-flop, and the result
//               is offered over a second valid/ready handshake.
//
//               Optional carry-in: define SERIAL_ADD_CIN_EN to add the cin
//               port, which seeds the carry register on accept. Without the
//               macro the carry register is seeded with 0.
//
// Ports       : clk        clock, rising edge
//               rst_n      synchronous active-low reset
//               in_valid   operand pair present on a/b
//               in_ready   ready to accept operands (IDLE only)
//               a, b       WIDTH-bit operands, sampled on the accept edge
//               cin        carry-in (SERIAL_ADD_CIN_EN builds only)
//               out_valid  sum/cout valid, held until out_ready
//               out_ready  consumer takes the result
//               sum        a + b (+cin) mod 2^WIDTH
//               cout       carry out of bit WIDTH-1
//               busy       high while adding or holding a result
// Revision    : 1.0  initial release
// ============================================================================
module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_c;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_s;
    logic               w_c;
    logic               w_cin;

    // The single full-adder cell, fed from the operand LSBs and the carry loop.
    assign w_s = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c = (r_a[0] & r_b[0]) | (r_b[0] & r_c) | (r_c & r_a[0]);

`ifdef SERIAL_ADD_CIN_EN
    assign w_cin = cin;
`else
    assign w_cin = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_c        <= w_cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ADD;
                    end
                end

                S_ADD: begin
                    // Each new sum bit enters at the MSB; after WIDTH shifts
                    // the first (bit 0) result has walked down to the LSB.
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c;
                    if (r_cnt == c_LAST) begin
                        r_cnt       <= '0;
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule
`default_nettype wire
